float_to_fixed: RTL
===================

Name: float_to_fixed

Overview:
- Multi-cycle converter that consumes a packed 10-bit float result word and its overflow flag, as produced by the team's floating-point adder datapath.
- Produces an unsigned fixed-point integer for downstream integer logic.
- Iterative one-bit-per-cycle shifter under FSM control, with valid/ready handshakes on both sides.
- Float format: bits[9:6] biased exponent E; bits[5:0] significand S with an explicit leading one at bit 5 when normalized. Value = S/32 * 2^(E-BIAS).

Parameters:
- BIAS, 7, exponent bias.
- FRAC_BITS, 4, fractional bits in the fixed-point output.
- OUT_W, 16, output width; must be ≥ 13.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_overflow valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  10  packed float {E[3:0], S[5:0]}.
- in_overflow  input  1  upstream overflow flag; forces saturation.
- out_valid  output  1  out_data/out_sat valid; high only in DONE.
- out_ready  input  1  consumer accepts.
- out_data  output  OUT_W  fixed-point result, FRAC_BITS fraction bits.
- out_sat  output  1  result was saturated to all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_sat=0, accumulator/counter/round bit=0. Reset mid-conversion aborts it; no output is produced.
- Shift amount: s = E − BIAS − 5 + FRAC_BITS, signed; −8..7 with defaults. s<0 shifts right by |s|; s>0 shifts left by s.
- States: IDLE, SHIFT, ROUND, DONE.
- IDLE, on in_valid & in_ready:
  - in_overflow=1 → out_data=all-ones, out_sat=1, go to DONE.
  - else S==0 → out_data=0, out_sat=0, go to DONE.
  - else acc = S zero-extended to OUT_W, cnt=|s|, dir=sign(s), rbit=0, sat=0, go to SHIFT.
- SHIFT, cnt≠0, one bit per cycle, cnt−1:
  - Right shift: rbit ← acc[0], then acc>>1.
  - Left shift: if acc[OUT_W−1]=1, set sat; then acc<<1.
- SHIFT, cnt==0: go to ROUND; no shift this cycle.
- ROUND:
  - sat=1 → out_data=all-ones, out_sat=1.
  - else rbit=1 → acc+1, round-half-up; if the increment wraps to 0, out_data=all-ones, out_sat=1.
  - else out_data=acc.
  - Go to DONE.
- DONE: out_valid=1; out_data/out_sat held stable. On out_ready=1, go to IDLE and drop out_valid the same edge. out_data keeps its last value after leaving DONE.
- Latency from accepting edge to out_valid high:
  - |s|+2 edges on the normal path.
  - 1 edge on the overflow/zero fast path.
- Throughput: one conversion in flight. in_ready=0 from acceptance until the DONE→IDLE edge.
- in_data/in_overflow are sampled only on the accepting edge; later changes are ignored.
- out_ready while not in DONE is ignored.
- No combinational path from in_* to out_*.

Test Plan:
- in_data={E=8,S=100000b}, overflow=0 → s=0; out_data=0x0020, out_sat=0; out_valid 2 edges after accept.
- {E=15,S=111111b} → s=7; out_data=0x1F80, out_sat=0, out_valid 9 edges after accept. Same input with OUT_W=12 → out_data=0xFFF, out_sat=1.
- Rounding:
  - {E=3,S=110000b} → s=−5, 48>>5=1, last bit out 1 → out_data=0x0002.
  - {E=7,S=101000b} → out_data=0x0014.
  - {E=0,S=100001b} → out_data=0x0000.
- Fast paths:
  - in_overflow=1, any in_data → out_data=0xFFFF, out_sat=1, out_valid 1 edge after accept.
  - S=0 with E=12 → out_data=0, out_sat=0, 1-edge latency.
- Backpressure/handshake:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid and out_data stable, in_ready=0, new in_valid ignored.
  - Raise out_ready → next edge in_ready=1.
  - Back-to-back inputs are each accepted only when in_ready=1.
- Assert reset low mid-SHIFT (E=15 case, cycle 3) → immediately out_valid=0, in_ready=1, out_data=0; after release a fresh {E=8,S=100000b} converts to 0x0020.

Source files
------------

// File: rtl/float_to_fixed_if.sv
// Handshake bundle between a float_to_fixed converter and its producer/consumer.
// Valid/ready: a word moves on a rising edge where valid and ready are both high;
// the sender holds data stable while valid is high and ready is low.
interface float_to_fixed_if #(
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       in_data;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_overflow, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_overflow, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/float_to_fixed.sv
// Converts a packed {E[3:0], S[5:0]} float into an unsigned fixed-point integer,
// shifting one bit per cycle and rounding half-up on the last bit shifted out.
module float_to_fixed #(
  parameter int BIAS      = 7,
  parameter int FRAC_BITS = 4,
  parameter int OUT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  float_to_fixed_if.slave    bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CNT_W = 5;
  // Signed shift offset: s = E - BIAS - 5 + FRAC_BITS, the 5 being the significand's binary point.
  localparam logic signed [7:0] S_OFF = 8'(FRAC_BITS - BIAS - 5);

  state_t           state, state_n;
  logic [OUT_W-1:0] acc, acc_n, acc_inc;
  logic [OUT_W-1:0] data_q, data_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             left, left_n;
  logic             rbit, rbit_n;
  logic             sat, sat_n;
  logic             osat_q, osat_n;
  logic [3:0]       in_e;
  logic [5:0]       in_s;
  logic signed [7:0] shamt;

  assign in_e    = bus.in_data[9:6];
  assign in_s    = bus.in_data[5:0];
  assign shamt   = $signed({4'b0000, in_e}) + S_OFF;
  assign acc_inc = acc + OUT_W'(1);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_sat   = osat_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      left   <= 1'b0;
      rbit   <= 1'b0;
      sat    <= 1'b0;
      data_q <= '0;
      osat_q <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      left   <= left_n;
      rbit   <= rbit_n;
      sat    <= sat_n;
      data_q <= data_n;
      osat_q <= osat_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    left_n  = left;
    rbit_n  = rbit;
    sat_n   = sat;
    data_n  = data_q;
    osat_n  = osat_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_overflow) begin
            data_n  = '1;
            osat_n  = 1'b1;
            state_n = DONE;
          end else if (in_s == 6'd0) begin
            data_n  = '0;
            osat_n  = 1'b0;
            state_n = DONE;
          end else begin
            acc_n   = OUT_W'(in_s);
            cnt_n   = shamt[7] ? CNT_W'(-shamt) : CNT_W'(shamt);
            left_n  = ~shamt[7];
            rbit_n  = 1'b0;
            sat_n   = 1'b0;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          state_n = ROUND;
        end else begin
          cnt_n = cnt - CNT_W'(1);
          if (left) begin
            // A one leaving the top bit means the value no longer fits.
            if (acc[OUT_W-1]) sat_n = 1'b1;
            acc_n = {acc[OUT_W-2:0], 1'b0};
          end else begin
            rbit_n = acc[0];
            acc_n  = {1'b0, acc[OUT_W-1:1]};
          end
        end
      end
      ROUND: begin
        if (sat || (rbit && (acc_inc == '0))) begin
          data_n = '1;
          osat_n = 1'b1;
        end else if (rbit) begin
          data_n = acc_inc;
          osat_n = 1'b0;
        end else begin
          data_n = acc;
          osat_n = 1'b0;
        end
        state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
